halving_seq: RTL
================

Name: halving_seq

Overview:
- Sequential inverse of the combinational mask-doubling unit. It computes the mask k steps back, i.e. the mask before k doublings. Each cycle it applies one multiply by x^-1 in GF(2^128), with polynomial x^128+x^7+x^2+x+1.
- It uses the same byte ordering and the same domain-byte (dold/dnew) injection as doubling.
- It is the backward mask walk for the decryption / tag-verify path. A valid/ready handshake sits on both sides.

Parameters:
- CNT_W, 4, width of the step-count input. Maximum steps per request is 2^CNT_W-1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- in_state  input  128  mask value, in doubling-output byte order.
- in_dold  input  8  domain byte XORed at doubling input; held for the whole request.
- in_dnew  input  8  domain byte XORed at doubling output; held for the whole request.
- in_count  input  CNT_W  number of halving steps k.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_state  output  128  result after k halvings.

Behaviour:
Single halving step h(s, dold, dnew). It is the exact inverse of doubling, so doubling(h(s,dold,dnew),dold,dnew) = s.
- Step 1: t = s with t[7:0] ^= dnew.
- Step 2: lo = byte-reverse(t). lo[127:120]=t[7:0], and so on, down to lo[7:0]=t[127:120].
- Step 3: b = lo[0]. m = lo ^ ({b at bits 7, 2, 1}).
- Step 4: li = rotate-right-1(m), so li[127]=m[0].
- Step 5: r = byte-reverse(li), then r[7:0] ^= dold. Result is r.

Domain bytes:
- dold and dnew are latched at acceptance.
- They are applied on every step of that request.

FSM states: IDLE, RUN, DONE. Internal registers: acc[127:0], rem[CNT_W-1:0], dold_q, dnew_q.

IDLE:
- in_ready=1.
- On in_valid: latch acc=in_state, dold_q/dnew_q, rem=in_count.
- If in_count==0, go to DONE. Otherwise go to RUN.

RUN:
- in_ready=0.
- Each cycle: acc=h(acc,dold_q,dnew_q) and rem=rem-1.
- When rem==1, go to DONE in the same edge.

DONE:
- out_valid=1 and out_state=acc, held stable while out_ready=0.
- On out_ready: go to IDLE.

Latency:
- With the accepting edge E0, out_valid is visible after edge E0+k. For k=0 it is visible right after E0.
- One step per cycle. There is no extra output register.

Back-to-back and pipelining:
- No new request is accepted in the DONE handshake cycle. in_ready rises the cycle after out_ready is sampled.
- Minimum request period is k+2 cycles.
- There is no overlap or pipelining between requests.

Reset values (rst_n=0, asynchronous):
- in_ready=0 while rst_n is low, then 1 in IDLE.
- out_valid=0 and out_state=0.
- acc, rem, dold_q and dnew_q are all 0.

Other rules:
- Reset mid-RUN or mid-DONE aborts the request. No result is produced and the FSM returns to IDLE.
- in_state, in_dold, in_dnew and in_count are ignored outside the IDLE acceptance cycle.
- out_ready is ignored outside DONE.
- All arithmetic is XOR/rotate, with no carries. rem never wraps, because DONE is entered on rem==1.

Test Plan:
- Plain shift: in_state=128'h00..01 (byte [7:0]=0x01), dold=dnew=0, k=1 -> out_state=128'h00..8000; out_valid one cycle after accept.
- Feedback path: in_state=128'h01 followed by thirty 0 nibbles (only [127:120]=0x01), dold=dnew=0, k=1 -> out_state=128'h43 followed by zeros, ending in ..0080.
- Round trip: 1000 random (s, dold, dnew, k in 0..15); feed the result through k chained doubling instances -> must equal s. Check out_valid rises exactly k cycles after accept.
- k=0: in_state=random X -> out_valid after 1 edge with out_state=X; hold out_ready=0 for 5 cycles -> out_state and out_valid stable, in_ready=0.
- Backpressure and back-to-back: two requests with in_valid held high -> second accepted only the cycle after the first out handshake; results in order.
- Reset: assert rst_n=0 mid-RUN (k=10, after 4 steps) -> out_valid=0 immediately (async); after release, in_ready=1 and a fresh k=1 request gives the correct result.

Source files
------------

// File: rtl/halving_seq.sv
// Backward mask walk: applies k multiplications by x^-1 in GF(2^128), one per cycle,
// using the byte order and domain-byte injection of the mask-doubling unit.
module halving_seq #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [127:0]     in_state,
   input  logic [7:0]       in_dold,
   input  logic [7:0]       in_dnew,
   input  logic [CNT_W-1:0] in_count,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [127:0]     out_state
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q;
   logic [127:0]     acc_q;
   logic [127:0]     acc_d;
   logic [CNT_W-1:0] rem_q;
   logic [7:0]       dold_q;
   logic [7:0]       dnew_q;
   logic             in_ready_q;
   logic             out_valid_q;

   function automatic logic [127:0] byte_rev(input logic [127:0] v);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) begin
         r[8*i +: 8] = v[127-8*i -: 8];
      end
      return r;
   endfunction

   // Undo doubling: strip dnew, reduce by the polynomial if the low bit is set,
   // rotate right by one, then restore byte order and re-inject dold.
   function automatic logic [127:0] halve(input logic [127:0] s,
                                          input logic [7:0]   dold,
                                          input logic [7:0]   dnew);
      logic [127:0] t;
      logic [127:0] m;
      logic [127:0] r;
      t       = s;
      t[7:0]  = t[7:0] ^ dnew;
      m       = byte_rev(t);
      if (m[0]) begin
         m = m ^ 128'h86;
      end
      r       = byte_rev({m[0], m[127:1]});
      r[7:0]  = r[7:0] ^ dold;
      return r;
   endfunction

   always_comb begin
      acc_d = halve(acc_q, dold_q, dnew_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         rem_q       <= '0;
         dold_q      <= '0;
         dnew_q      <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid && in_ready_q) begin
                  acc_q      <= in_state;
                  dold_q     <= in_dold;
                  dnew_q     <= in_dnew;
                  rem_q      <= in_count;
                  in_ready_q <= 1'b0;
                  if (in_count == '0) begin
                     state_q     <= DONE;
                     out_valid_q <= 1'b1;
                  end else begin
                     state_q <= RUN;
                  end
               end else begin
                  in_ready_q <= 1'b1;
               end
            end
            RUN: begin
               acc_q <= acc_d;
               rem_q <= rem_q - CNT_W'(1);
               if (rem_q == CNT_W'(1)) begin
                  state_q     <= DONE;
                  out_valid_q <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q     <= IDLE;
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_state = acc_q;

endmodule
